bitstream_fetch_ctrl: RTL

//  Refill controller for the parser bit window. Tracks the parser bit pointer (pc, next-value form),

---
 rtl/bitstream_fetch_ctrl.sv | 126 ++++++++++++
 1 files changed

// File: rtl/bitstream_fetch_ctrl.sv
// Refill controller for the parser bit window: fetches 32-bit stream words into a ring
// indexed by word address and presents a registered 32-bit MSB-first window at pc.
module bitstream_fetch_ctrl #(
  parameter int BUF_WORDS = 4,
  parameter int ADDR_W    = 24
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [31:0]                  pc,
  output logic                         mem_req,
  output logic [ADDR_W-1:0]            mem_addr,
  input  logic                         mem_ack,
  input  logic [31:0]                  mem_rdata,
  output logic [31:0]                  bits_window,
  output logic                         window_valid,
  output logic                         parser_stall,
  output logic [$clog2(BUF_WORDS):0]   fill_level,
  output logic [1:0]                   state_dbg
);

  localparam int CNT_W = $clog2(BUF_WORDS) + 1;
  localparam int PTR_W = $clog2(BUF_WORDS);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_REQ       = 2'd1;
  localparam logic [1:0] S_REQ_STALE = 2'd2;

  // Handshake: mem_req stays high with mem_addr frozen until the cycle mem_ack is
  // sampled high at a rising edge; mem_rdata is taken in that same cycle.

  logic [1:0]        state, state_n;
  logic [26:0]       base_word;
  logic [CNT_W-1:0]  count;
  logic [31:0]       ring [BUF_WORDS];

  logic [26:0]       pw;
  logic [4:0]        pb;
  logic [26:0]       fetch_word;
  logic              in_range;
  logic              take;
  logic [CNT_W-1:0]  count_post;
  logic [PTR_W-1:0]  tail_idx, idx0, idx1;
  logic [31:0]       word0, word1, win_next;
  logic              win_ok;
  logic              req_n;
  logic [ADDR_W-1:0] addr_n;

  assign pw         = pc[31:5];
  assign pb         = pc[4:0];
  assign fetch_word = base_word + 27'(count);
  assign in_range   = (pw >= base_word) && (pw <= fetch_word);
  // A flush in REQ discards the data arriving in the same cycle.
  assign take       = (state == S_REQ) && mem_ack && in_range;
  assign count_post = in_range ? (CNT_W'(fetch_word - pw) + CNT_W'(take)) : '0;

  // Eviction leaves fetch_word unchanged, so the tail slot is the pre-update one.
  assign tail_idx = fetch_word[PTR_W-1:0];
  assign idx0     = pw[PTR_W-1:0];
  assign idx1     = idx0 + PTR_W'(1);
  assign word0    = (take && (tail_idx == idx0)) ? mem_rdata : ring[idx0];
  assign word1    = (take && (tail_idx == idx1)) ? mem_rdata : ring[idx1];
  assign win_ok   = count_post >= CNT_W'(2);
  assign win_next = (word0 << pb) | (word1 >> (6'd32 - {1'b0, pb}));

  always_comb begin
    state_n = state;
    req_n   = mem_req;
    addr_n  = mem_addr;
    case (state)
      S_IDLE: begin
        if (count_post < CNT_W'(BUF_WORDS)) begin
          state_n = S_REQ;
          req_n   = 1'b1;
          addr_n  = ADDR_W'(pw + 27'(count_post));
        end
      end
      S_REQ, S_REQ_STALE: begin
        if (mem_ack) begin
          if (count_post < CNT_W'(BUF_WORDS)) begin
            state_n = S_REQ;
            req_n   = 1'b1;
            addr_n  = ADDR_W'(pw + 27'(count_post));
          end else begin
            state_n = S_IDLE;
            req_n   = 1'b0;
          end
        end else if (!in_range) begin
          state_n = S_REQ_STALE;
        end
      end
      default: begin
        state_n = S_IDLE;
        req_n   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      base_word    <= '0;
      count        <= '0;
      mem_req      <= 1'b0;
      mem_addr     <= '0;
      bits_window  <= '0;
      window_valid <= 1'b0;
    end else begin
      state     <= state_n;
      base_word <= pw;
      count     <= count_post;
      mem_req   <= req_n;
      mem_addr  <= addr_n;
      window_valid <= win_ok;
      if (win_ok) bits_window <= win_next;
    end
  end

  always_ff @(posedge clk) begin
    if (take) ring[tail_idx] <= mem_rdata;
  end

  assign parser_stall = ~window_valid;
  assign fill_level   = count;
  assign state_dbg    = state;

endmodule
